sys_arbiter: RTL and testbench

SYS_ARBITER -- requirements
Module: sys_arbiter

---
 rtl/sys_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sys_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sys_arbiter.sv
// Shares one system memory port between an I-side and a D-side requester.
// Three-state FSM (IDLE/ACCESS/DONE) with round-robin arbitration on ties.
module sys_arbiter #(
    parameter int MEM_WAIT = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        i_strobe,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_ready,

    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,

    output logic        m_strobe,
    output logic        m_rw,
    output logic [11:0] m_address,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic [1:0]  grant
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic [3:0] WAIT_LOAD  = 4'(MEM_WAIT - 1);

    // On a tie the side not served last wins; last_d == 0 means I was served last.
    function automatic logic [1:0] arbitrate(input logic i_req, input logic d_req,
                                             input logic last_d);
        logic [1:0] pick;
        if (i_req && d_req) begin
            pick = last_d ? GRANT_I : GRANT_D;
        end else if (d_req) begin
            pick = GRANT_D;
        end else if (i_req) begin
            pick = GRANT_I;
        end else begin
            pick = GRANT_NONE;
        end
        return pick;
    endfunction

    logic [1:0]  state_r;
    logic [3:0]  wait_cnt_r;
    logic        last_d_r;
    logic [1:0]  pick_s;
    logic        sel_rw_s;
    logic [31:0] sel_address_s;
    logic [31:0] sel_wdata_s;
    logic        unused_addr_s;

    // Only the low 12 address bits reach the memory port.
    assign unused_addr_s = ^{i_address[31:12], d_address[31:12]};

    // Arbitration decision and multiplexing of the winning request fields.
    always_comb begin
        pick_s        = arbitrate(i_strobe, d_strobe, last_d_r);
        sel_rw_s      = 1'b1;
        sel_address_s = 32'd0;
        sel_wdata_s   = 32'd0;
        if (pick_s == GRANT_D) begin
            sel_rw_s      = d_rw;
            sel_address_s = d_address;
            sel_wdata_s   = d_wdata;
        end else begin
            sel_rw_s      = i_rw;
            sel_address_s = i_address;
            sel_wdata_s   = i_wdata;
        end
    end

    // FSM, memory port drive, rdata capture and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            last_d_r   <= 1'b0;
            m_strobe   <= 1'b0;
            m_rw       <= 1'b1;
            m_address  <= 12'd0;
            m_wdata    <= 32'd0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= 32'd0;
            d_rdata    <= 32'd0;
            busy       <= 1'b0;
            grant      <= GRANT_NONE;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_s != GRANT_NONE) begin
                        state_r    <= ST_ACCESS;
                        grant      <= pick_s;
                        busy       <= 1'b1;
                        m_strobe   <= 1'b1;
                        m_rw       <= sel_rw_s;
                        m_address  <= sel_address_s[11:0];
                        m_wdata    <= sel_wdata_s;
                        wait_cnt_r <= WAIT_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // m_rw still carries the latched direction during ACCESS.
                    if (wait_cnt_r == 4'd0) begin
                        state_r  <= ST_DONE;
                        m_strobe <= 1'b0;
                        m_rw     <= 1'b1;
                        if (grant == GRANT_D) begin
                            d_ready <= 1'b1;
                            if (m_rw) begin
                                d_rdata <= m_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            if (m_rw) begin
                                i_rdata <= m_rdata;
                            end else begin
                                i_rdata <= i_rdata;
                            end
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    grant    <= GRANT_NONE;
                    last_d_r <= (grant == GRANT_D);
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    grant    <= GRANT_NONE;
                    m_strobe <= 1'b0;
                    m_rw     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_arbiter.sv
// Self-checking bench for sys_arbiter: vector table, scoreboard of expected
// read data, and hand sequences for tie arbitration, mid-access reset and strobe drop.
module tb_sys_arbiter;

    localparam int MW = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_strobe, i_rw, d_strobe, d_rw;
    logic [31:0] i_address, i_wdata, d_address, d_wdata;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic        i_ready, d_ready, m_strobe, m_rw, busy;
    logic [11:0] m_address;
    logic [1:0]  grant;

    always #5 clock = ~clock;

    sys_arbiter #(.MEM_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .i_strobe(i_strobe), .i_rw(i_rw), .i_address(i_address), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_strobe(d_strobe), .d_rw(d_rw), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_strobe(m_strobe), .m_rw(m_rw), .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .grant(grant)
    );

    typedef struct {
        logic        side_d;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        logic [1:0]  exp_grant;
        logic [11:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        side_d;
        logic [31:0] rdata;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[5];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        i_strobe = 1'b0;
        d_strobe = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit drop_early);
        sb_t e;
        @(negedge clock);
        if (v.side_d) begin
            d_strobe = 1'b1; d_rw = v.rw; d_address = v.addr; d_wdata = v.wdata;
        end else begin
            i_strobe = 1'b1; i_rw = v.rw; i_address = v.addr; i_wdata = v.wdata;
        end
        m_rdata = v.mrdata;
        sb.push_back('{v.side_d, v.exp_rdata});
        for (int c = 1; c <= MW; c++) begin
            @(negedge clock);
            check("acc_m_strobe", 32'(m_strobe), 32'd1);
            check("acc_m_rw", 32'(m_rw), 32'(v.rw));
            check("acc_m_address", 32'(m_address), 32'(v.exp_maddr));
            check("acc_m_wdata", m_wdata, v.wdata);
            check("acc_grant", 32'(grant), 32'(v.exp_grant));
            check("acc_busy", 32'(busy), 32'd1);
            if (drop_early && c == 1) begin
                if (v.side_d) begin
                    d_strobe = 1'b0; d_address = 32'hFFFF_FFFF; d_wdata = 32'hFFFF_FFFF; d_rw = ~v.rw;
                end else begin
                    i_strobe = 1'b0; i_address = 32'hFFFF_FFFF; i_wdata = 32'hFFFF_FFFF; i_rw = ~v.rw;
                end
            end
        end
        @(negedge clock);
        check("done_ready", 32'(v.side_d ? d_ready : i_ready), 32'd1);
        check("done_other_ready", 32'(v.side_d ? i_ready : d_ready), 32'd0);
        check("done_m_strobe", 32'(m_strobe), 32'd0);
        check("done_m_rw", 32'(m_rw), 32'd1);
        check("done_m_address_hold", 32'(m_address), 32'(v.exp_maddr));
        check("done_busy", 32'(busy), 32'd1);
        check("done_grant", 32'(grant), 32'(v.exp_grant));
        if (i_ready || d_ready) begin
            e = sb.pop_front();
            check("sb_side", 32'(d_ready), 32'(e.side_d));
            check("sb_rdata", e.side_d ? d_rdata : i_rdata, e.rdata);
        end
        i_strobe = 1'b0;
        d_strobe = 1'b0;
        @(negedge clock);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_ready", 32'({i_ready, d_ready}), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        i_strobe = 1'b0; i_rw = 1'b1; i_address = 32'd0; i_wdata = 32'd0;
        d_strobe = 1'b0; d_rw = 1'b1; d_address = 32'd0; d_wdata = 32'd0;
        m_rdata = 32'd0;

        vecs[0] = '{1'b1, 1'b1, 32'h0000_0104, 32'h0000_0000, 32'hDEAD_BEEF, 2'b10, 12'h104, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0008, 32'h1234_5678, 32'hAAAA_5555, 2'b01, 12'h008, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hCAFE_F00D, 2'b01, 12'hFFC, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_1ABC, 32'h0BAD_F00D, 32'h7777_7777, 2'b10, 12'hABC, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 2'b01, 12'h000, 32'h0000_0001};

        // Reset values.
        @(negedge clock);
        check("rst_m_strobe", 32'(m_strobe), 32'd0);
        check("rst_m_rw", 32'(m_rw), 32'd1);
        check("rst_m_address", 32'(m_address), 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_ready", 32'({i_ready, d_ready}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], 1'b0);
        end

        // Simultaneous requests held continuously: D first, then alternate.
        apply_reset();
        i_rw = 1'b1; i_address = 32'h0000_0040; d_rw = 1'b1; d_address = 32'h0000_0080;
        m_rdata = 32'h5A5A_0001;
        i_strobe = 1'b1; d_strobe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clock);
            check("tie_grant", 32'(grant), 32'(exp_g));
            check("tie_m_address", 32'(m_address), (k % 2 == 0) ? 32'h080 : 32'h040);
            @(negedge clock);
            @(negedge clock);
            check("tie_i_ready", 32'(i_ready), 32'(exp_g == 2'b01));
            check("tie_d_ready", 32'(d_ready), 32'(exp_g == 2'b10));
            @(negedge clock);
            check("tie_bubble_grant", 32'(grant), 32'd0);
            check("tie_bubble_busy", 32'(busy), 32'd0);
        end
        i_strobe = 1'b0; d_strobe = 1'b0;

        // Reset in the second ACCESS cycle of a D read.
        apply_reset();
        d_strobe = 1'b1; d_rw = 1'b1; d_address = 32'h0000_0104; m_rdata = 32'h1111_2222;
        @(negedge clock);
        check("mid_m_strobe_c1", 32'(m_strobe), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_m_strobe", 32'(m_strobe), 32'd0);
        check("mid_grant", 32'(grant), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        d_strobe = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("mid_no_d_ready", 32'(d_ready), 32'd0);
        end
        check("mid_d_rdata", d_rdata, 32'd0);
        run_vec('{1'b1, 1'b1, 32'h0000_0104, 32'h0, 32'h3333_4444, 2'b10, 12'h104, 32'h3333_4444}, 1'b0);

        // Strobe and request fields dropped after one ACCESS cycle.
        run_vec('{1'b1, 1'b1, 32'h0000_0200, 32'h0, 32'h5555_6666, 2'b10, 12'h200, 32'h5555_6666}, 1'b1);
        run_vec('{1'b0, 1'b0, 32'h0000_0310, 32'hFACE_0001, 32'h0, 2'b01, 12'h310, 32'h0000_0000}, 1'b1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
